stopwatch_lap_datapath: RTL and testbench

STOPWATCH_LAP_DATAPATH -- requirements
Module: stopwatch_lap_datapath

---
 rtl/stopwatch_lap_datapath.sv | 278 +++++++++++++++++++++++++++
 tb/tb_stopwatch_lap_datapath.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_datapath.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_datapath
//
// Purpose: centisecond stopwatch with up/down counting, preset load and an
// optional lap-capture FIFO. A clock divider produces one time step every
// DIV = CLK_FREQ/TICK_FREQ running cycles. Time is held as hour:min:sec.msec
// and every field is registered.
//
// Configuration macro: STOPWATCH_LAP_BUFFER_EN
//   defined   -> first-word-fall-through lap FIFO of LAP_DEPTH entries
//   undefined -> no lap storage; lap outputs tied to zero, i_lap/i_lap_rd ignored
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   i_mode       0 = count up, 1 = count down
//   i_run_stop   level, 1 = running
//   i_clear      pulse: zero the time, flush the laps, clear the divider
//   i_load       pulse: load i_preset (saturated per field), clear the divider
//   i_preset     {hour[4:0], min[5:0], sec[5:0], msec[6:0]}
//   i_lap        pulse: capture the time as registered before this edge
//   i_lap_rd     pulse: pop the oldest lap
//   o_msec/o_sec/o_min/o_hour  current time
//   o_lap_data   oldest lap (same packing as i_preset), 0 when empty
//   o_lap_valid  lap buffer non-empty
//   o_lap_count  entries held
//   o_lap_ovf    sticky: a lap was dropped while the buffer was full
//   o_rollover   1-cycle pulse on an up-mode wrap to zero
//   o_done       1-cycle pulse on a down-mode arrival at zero
// -----------------------------------------------------------------------------
module stopwatch_lap_datapath #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_FREQ = 100,
   parameter int HOUR_MAX  = 24,
   parameter int LAP_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_mode,
   input  logic                             i_run_stop,
   input  logic                             i_clear,
   input  logic                             i_load,
   input  logic [23:0]                      i_preset,
   input  logic                             i_lap,
   input  logic                             i_lap_rd,
   output logic [6:0]                       o_msec,
   output logic [5:0]                       o_sec,
   output logic [5:0]                       o_min,
   output logic [4:0]                       o_hour,
   output logic [23:0]                      o_lap_data,
   output logic                             o_lap_valid,
   output logic [$clog2(LAP_DEPTH+1)-1:0]   o_lap_count,
   output logic                             o_lap_ovf,
   output logic                             o_rollover,
   output logic                             o_done
);

   localparam int DIV   = CLK_FREQ / TICK_FREQ;
   localparam int DIV_W = $clog2(DIV);
   localparam int CNT_W = $clog2(LAP_DEPTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [4:0]       HOUR_LAST = 5'(HOUR_MAX - 1);

   // Clamp helpers for preset loading: an out-of-range field becomes its maximum.
   function automatic logic [6:0] sat_msec(input logic [6:0] v);
      logic [6:0] r;
      if (v > 7'd99) r = 7'd99;
      else           r = v;
      return r;
   endfunction

   function automatic logic [5:0] sat_sixty(input logic [5:0] v);
      logic [5:0] r;
      if (v > 6'd59) r = 6'd59;
      else           r = v;
      return r;
   endfunction

   function automatic logic [4:0] sat_hour(input logic [4:0] v);
      logic [4:0] r;
      if (v > HOUR_LAST) r = HOUR_LAST;
      else               r = v;
      return r;
   endfunction

   logic [DIV_W-1:0] div_r;
   logic [6:0]       msec_r, nxt_msec_s;
   logic [5:0]       sec_r,  nxt_sec_s;
   logic [5:0]       min_r,  nxt_min_s;
   logic [4:0]       hour_r, nxt_hour_s;
   logic             rollover_r, rollover_s;
   logic             done_r, done_s;
   logic             step_s, is_zero_s, at_one_s;
   logic [23:0]      cur_time_s;

   assign step_s     = i_run_stop && (div_r == DIV_LAST);
   assign is_zero_s  = (hour_r == 5'd0) && (min_r == 6'd0) && (sec_r == 6'd0) && (msec_r == 7'd0);
   assign at_one_s   = (hour_r == 5'd0) && (min_r == 6'd0) && (sec_r == 6'd0) && (msec_r == 7'd1);
   assign cur_time_s = {hour_r, min_r, sec_r, msec_r};

   // Tick divider: counts only while running, restarts on clear or load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_r <= '0;
      end else if (i_clear || i_load) begin
         div_r <= '0;
      end else if (i_run_stop) begin
         if (div_r == DIV_LAST) div_r <= '0;
         else                   div_r <= div_r + DIV_W'(1);
      end
   end

   // Next-time computation for one step: carry cascade up, borrow cascade down.
   always_comb begin
      nxt_msec_s = msec_r;
      nxt_sec_s  = sec_r;
      nxt_min_s  = min_r;
      nxt_hour_s = hour_r;
      rollover_s = 1'b0;
      done_s     = 1'b0;
      if (i_mode == 1'b0) begin
         if (msec_r == 7'd99) begin
            nxt_msec_s = 7'd0;
            if (sec_r == 6'd59) begin
               nxt_sec_s = 6'd0;
               if (min_r == 6'd59) begin
                  nxt_min_s = 6'd0;
                  if (hour_r == HOUR_LAST) begin
                     nxt_hour_s = 5'd0;
                     rollover_s = 1'b1;
                  end else begin
                     nxt_hour_s = hour_r + 5'd1;
                  end
               end else begin
                  nxt_min_s = min_r + 6'd1;
               end
            end else begin
               nxt_sec_s = sec_r + 6'd1;
            end
         end else begin
            nxt_msec_s = msec_r + 7'd1;
         end
      end else begin
         // Counting down parks at zero: no wrap and no repeated done pulse.
         if (is_zero_s) begin
            done_s = 1'b0;
         end else begin
            done_s = at_one_s;
            if (msec_r == 7'd0) begin
               nxt_msec_s = 7'd99;
               if (sec_r == 6'd0) begin
                  nxt_sec_s = 6'd59;
                  if (min_r == 6'd0) begin
                     // Not all-zero with lower fields zero implies hour > 0.
                     nxt_min_s  = 6'd59;
                     nxt_hour_s = hour_r - 5'd1;
                  end else begin
                     nxt_min_s = min_r - 6'd1;
                  end
               end else begin
                  nxt_sec_s = sec_r - 6'd1;
               end
            end else begin
               nxt_msec_s = msec_r - 7'd1;
            end
         end
      end
   end

   // Time registers and event pulses; priority clear > load > step.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         msec_r     <= 7'd0;
         sec_r      <= 6'd0;
         min_r      <= 6'd0;
         hour_r     <= 5'd0;
         rollover_r <= 1'b0;
         done_r     <= 1'b0;
      end else if (i_clear) begin
         msec_r     <= 7'd0;
         sec_r      <= 6'd0;
         min_r      <= 6'd0;
         hour_r     <= 5'd0;
         rollover_r <= 1'b0;
         done_r     <= 1'b0;
      end else if (i_load) begin
         msec_r     <= sat_msec(i_preset[6:0]);
         sec_r      <= sat_sixty(i_preset[12:7]);
         min_r      <= sat_sixty(i_preset[18:13]);
         hour_r     <= sat_hour(i_preset[23:19]);
         rollover_r <= 1'b0;
         done_r     <= 1'b0;
      end else if (step_s) begin
         msec_r     <= nxt_msec_s;
         sec_r      <= nxt_sec_s;
         min_r      <= nxt_min_s;
         hour_r     <= nxt_hour_s;
         rollover_r <= rollover_s;
         done_r     <= done_s;
      end else begin
         rollover_r <= 1'b0;
         done_r     <= 1'b0;
      end
   end

   assign o_msec     = msec_r;
   assign o_sec      = sec_r;
   assign o_min      = min_r;
   assign o_hour     = hour_r;
   assign o_rollover = rollover_r;
   assign o_done     = done_r;

`ifdef STOPWATCH_LAP_BUFFER_EN
   localparam int PTR_W = $clog2(LAP_DEPTH);

   logic [23:0]      lap_mem_r [LAP_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0] lap_cnt_r;
   logic             lap_ovf_r;
   logic             full_s, pop_s, push_s, drop_s;

   assign full_s = (lap_cnt_r == CNT_W'(LAP_DEPTH));
   assign pop_s  = i_lap_rd && (lap_cnt_r != '0);
   // A pop on the same edge frees the slot, so a full buffer still accepts the push.
   assign push_s = i_lap && (!full_s || pop_s);
   assign drop_s = i_lap && full_s && !pop_s;

   // Lap FIFO storage, pointers, occupancy and sticky overflow; clear drops any same-edge lap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LAP_DEPTH; i++) begin
            lap_mem_r[i] <= 24'd0;
         end
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         lap_cnt_r <= '0;
         lap_ovf_r <= 1'b0;
      end else if (i_clear) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         lap_cnt_r <= '0;
         lap_ovf_r <= 1'b0;
      end else begin
         if (push_s) begin
            lap_mem_r[wr_ptr_r] <= cur_time_s;
            wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   lap_cnt_r <= lap_cnt_r + CNT_W'(1);
            2'b01:   lap_cnt_r <= lap_cnt_r - CNT_W'(1);
            default: lap_cnt_r <= lap_cnt_r;
         endcase
         if (drop_s) begin
            lap_ovf_r <= 1'b1;
         end
      end
   end

   assign o_lap_valid = (lap_cnt_r != '0);
   assign o_lap_data  = o_lap_valid ? lap_mem_r[rd_ptr_r] : 24'd0;
   assign o_lap_count = lap_cnt_r;
   assign o_lap_ovf   = lap_ovf_r;
`else
   logic lap_unused_s;
   logic [23:0] time_unused_s;

   assign lap_unused_s  = i_lap ^ i_lap_rd;
   assign time_unused_s = cur_time_s;
   assign o_lap_valid   = 1'b0;
   assign o_lap_data    = 24'd0;
   assign o_lap_count   = '0;
   assign o_lap_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_lap_datapath.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_lap_datapath
//
// Directed self-checking bench for stopwatch_lap_datapath with DIV = 10,
// HOUR_MAX = 24, LAP_DEPTH = 4. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge. Lap-FIFO scenarios follow the
// STOPWATCH_LAP_BUFFER_EN macro; without it the tie-offs are checked instead.
// -----------------------------------------------------------------------------
module tb_stopwatch_lap_datapath;

   logic        clk;
   logic        reset;
   logic        i_mode, i_run_stop, i_clear, i_load, i_lap, i_lap_rd;
   logic [23:0] i_preset;
   logic [6:0]  o_msec;
   logic [5:0]  o_sec, o_min;
   logic [4:0]  o_hour;
   logic [23:0] o_lap_data;
   logic        o_lap_valid, o_lap_ovf, o_rollover, o_done;
   logic [2:0]  o_lap_count;
   logic [23:0] time_now;

   int checks = 0;
   int errors = 0;

   assign time_now = {o_hour, o_min, o_sec, o_msec};

   stopwatch_lap_datapath #(
      .CLK_FREQ (1000),
      .TICK_FREQ(100),
      .HOUR_MAX (24),
      .LAP_DEPTH(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_mode     (i_mode),
      .i_run_stop (i_run_stop),
      .i_clear    (i_clear),
      .i_load     (i_load),
      .i_preset   (i_preset),
      .i_lap      (i_lap),
      .i_lap_rd   (i_lap_rd),
      .o_msec     (o_msec),
      .o_sec      (o_sec),
      .o_min      (o_min),
      .o_hour     (o_hour),
      .o_lap_data (o_lap_data),
      .o_lap_valid(o_lap_valid),
      .o_lap_count(o_lap_count),
      .o_lap_ovf  (o_lap_ovf),
      .o_rollover (o_rollover),
      .o_done     (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [23:0] pack(input int h, input int m, input int s, input int ms);
      return {5'(h), 6'(m), 6'(s), 7'(ms)};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [23:0] p);
      i_preset = p;
      i_load   = 1'b1;
      tick(1);
      i_load   = 1'b0;
   endtask

   task automatic do_clear();
      i_clear = 1'b1;
      tick(1);
      i_clear = 1'b0;
   endtask

   task automatic do_lap();
      i_lap = 1'b1;
      tick(1);
      i_lap = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; i_mode = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0;
      i_load = 1'b0; i_lap = 1'b0; i_lap_rd = 1'b0; i_preset = 24'd0;
      #12;
      checks++;
      if (time_now !== 24'd0 || o_rollover !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_time: time=%h ro=%b done=%b expected 000000 0 0", time_now, o_rollover, o_done);
      end
      checks++;
      if (o_lap_valid !== 1'b0 || o_lap_count !== 3'd0 || o_lap_ovf !== 1'b0 || o_lap_data !== 24'd0) begin
         errors++;
         $display("FAIL reset_lap: valid=%b cnt=%0d ovf=%b data=%h expected 0 0 0 000000",
                  o_lap_valid, o_lap_count, o_lap_ovf, o_lap_data);
      end
      @(negedge clk);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_run_hold();
      i_run_stop = 1'b1;
      tick(30);
      checks++;
      if (time_now !== pack(0, 0, 0, 3)) begin
         errors++;
         $display("FAIL run_30: time=%h expected %h", time_now, pack(0, 0, 0, 3));
      end
      i_run_stop = 1'b0;
      tick(50);
      checks++;
      if (o_msec !== 7'd3) begin
         errors++;
         $display("FAIL stop_hold: msec=%0d expected 3", o_msec);
      end
      i_run_stop = 1'b1;
      tick(10);
      checks++;
      if (o_msec !== 7'd4) begin
         errors++;
         $display("FAIL resume: msec=%0d expected 4", o_msec);
      end
      i_run_stop = 1'b0;
   endtask

   task automatic test_load_sat();
      do_load({5'd31, 6'd63, 6'd63, 7'd127});
      checks++;
      if (time_now !== pack(23, 59, 59, 99)) begin
         errors++;
         $display("FAIL load_sat: time=%h expected %h", time_now, pack(23, 59, 59, 99));
      end
      do_load(pack(12, 34, 56, 78));
      checks++;
      if (time_now !== pack(12, 34, 56, 78)) begin
         errors++;
         $display("FAIL load_plain: time=%h expected %h", time_now, pack(12, 34, 56, 78));
      end
   endtask

   task automatic test_carry();
      do_load(pack(5, 9, 59, 99));
      i_mode = 1'b0;
      i_run_stop = 1'b1;
      tick(10);
      i_run_stop = 1'b0;
      checks++;
      if (time_now !== pack(5, 10, 0, 0) || o_rollover !== 1'b0) begin
         errors++;
         $display("FAIL carry: time=%h ro=%b expected %h 0", time_now, o_rollover, pack(5, 10, 0, 0));
      end
   endtask

   task automatic test_rollover();
      int ro_cnt;
      ro_cnt = 0;
      do_load(pack(23, 59, 59, 99));
      i_mode = 1'b0;
      i_run_stop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (o_rollover === 1'b1) ro_cnt++;
      end
      checks++;
      if (time_now !== 24'd0) begin
         errors++;
         $display("FAIL rollover_time: time=%h expected 000000", time_now);
      end
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (o_rollover === 1'b1) ro_cnt++;
      end
      i_run_stop = 1'b0;
      checks++;
      if (ro_cnt !== 1) begin
         errors++;
         $display("FAIL rollover_pulse: high_cycles=%0d expected 1", ro_cnt);
      end
   endtask

   task automatic test_countdown();
      int done_cnt;
      do_load(pack(0, 0, 1, 0));
      i_mode = 1'b1;
      i_run_stop = 1'b1;
      tick(10);
      checks++;
      if (time_now !== pack(0, 0, 0, 99)) begin
         errors++;
         $display("FAIL down_first: time=%h expected %h", time_now, pack(0, 0, 0, 99));
      end
      done_cnt = 0;
      for (int i = 0; i < 990; i++) begin
         tick(1);
         if (o_done === 1'b1) done_cnt++;
      end
      checks++;
      if (time_now !== 24'd0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL down_zero: time=%h done_cycles=%0d expected 000000 1", time_now, done_cnt);
      end
      done_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (o_done === 1'b1) done_cnt++;
      end
      checks++;
      if (time_now !== 24'd0 || done_cnt !== 0) begin
         errors++;
         $display("FAIL down_hold: time=%h done_cycles=%0d expected 000000 0", time_now, done_cnt);
      end
      i_run_stop = 1'b0;
   endtask

   task automatic test_borrow_mode();
      do_load(pack(1, 0, 0, 0));
      i_mode = 1'b1;
      i_run_stop = 1'b1;
      tick(10);
      i_run_stop = 1'b0;
      checks++;
      if (time_now !== pack(0, 59, 59, 99)) begin
         errors++;
         $display("FAIL borrow: time=%h expected %h", time_now, pack(0, 59, 59, 99));
      end
      i_mode = 1'b0;
      tick(3);
      checks++;
      if (time_now !== pack(0, 59, 59, 99)) begin
         errors++;
         $display("FAIL mode_toggle: time=%h expected %h", time_now, pack(0, 59, 59, 99));
      end
      i_run_stop = 1'b1;
      tick(10);
      i_run_stop = 1'b0;
      checks++;
      if (time_now !== pack(1, 0, 0, 0)) begin
         errors++;
         $display("FAIL mode_up_after: time=%h expected %h", time_now, pack(1, 0, 0, 0));
      end
   endtask

`ifdef STOPWATCH_LAP_BUFFER_EN
   task automatic test_lap_overflow();
      logic [23:0] caps [5];
      caps[0] = pack(1, 2, 3, 4);
      caps[1] = pack(2, 3, 4, 5);
      caps[2] = pack(3, 4, 5, 6);
      caps[3] = pack(4, 5, 6, 7);
      caps[4] = pack(5, 6, 7, 8);
      do_clear();
      for (int k = 0; k < 5; k++) begin
         do_load(caps[k]);
         do_lap();
      end
      checks++;
      if (o_lap_count !== 3'd4 || o_lap_ovf !== 1'b1 || o_lap_valid !== 1'b1 || o_lap_data !== caps[0]) begin
         errors++;
         $display("FAIL lap_full: cnt=%0d ovf=%b valid=%b data=%h expected 4 1 1 %h",
                  o_lap_count, o_lap_ovf, o_lap_valid, o_lap_data, caps[0]);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_lap_data !== caps[k]) begin
            errors++;
            $display("FAIL lap_read%0d: data=%h expected %h", k, o_lap_data, caps[k]);
         end
         i_lap_rd = 1'b1;
         tick(1);
         i_lap_rd = 1'b0;
      end
      checks++;
      if (o_lap_valid !== 1'b0 || o_lap_count !== 3'd0) begin
         errors++;
         $display("FAIL lap_drained: valid=%b cnt=%0d expected 0 0", o_lap_valid, o_lap_count);
      end
      i_lap_rd = 1'b1;
      tick(1);
      i_lap_rd = 1'b0;
      checks++;
      if (o_lap_valid !== 1'b0 || o_lap_count !== 3'd0 || o_lap_ovf !== 1'b1 || o_lap_data !== 24'd0) begin
         errors++;
         $display("FAIL lap_rd_empty: valid=%b cnt=%0d ovf=%b data=%h expected 0 0 1 000000",
                  o_lap_valid, o_lap_count, o_lap_ovf, o_lap_data);
      end
   endtask

   task automatic test_lap_full_rw();
      logic [23:0] caps [5];
      caps[0] = pack(0, 1, 0, 10);
      caps[1] = pack(0, 2, 0, 20);
      caps[2] = pack(0, 3, 0, 30);
      caps[3] = pack(0, 4, 0, 40);
      caps[4] = pack(0, 5, 0, 50);
      do_clear();
      checks++;
      if (o_lap_ovf !== 1'b0) begin
         errors++;
         $display("FAIL clear_ovf: ovf=%b expected 0", o_lap_ovf);
      end
      for (int k = 0; k < 4; k++) begin
         do_load(caps[k]);
         do_lap();
      end
      do_load(caps[4]);
      i_lap = 1'b1;
      i_lap_rd = 1'b1;
      tick(1);
      i_lap = 1'b0;
      i_lap_rd = 1'b0;
      checks++;
      if (o_lap_count !== 3'd4 || o_lap_ovf !== 1'b0) begin
         errors++;
         $display("FAIL lap_push_pop: cnt=%0d ovf=%b expected 4 0", o_lap_count, o_lap_ovf);
      end
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (o_lap_data !== caps[k]) begin
            errors++;
            $display("FAIL lap_rw_read%0d: data=%h expected %h", k, o_lap_data, caps[k]);
         end
         i_lap_rd = 1'b1;
         tick(1);
         i_lap_rd = 1'b0;
      end
   endtask

   task automatic test_lap_prestep();
      do_clear();
      do_load(pack(0, 0, 0, 50));
      i_mode = 1'b0;
      i_run_stop = 1'b1;
      tick(9);
      i_lap = 1'b1;
      tick(1);
      i_lap = 1'b0;
      i_run_stop = 1'b0;
      checks++;
      if (time_now !== pack(0, 0, 0, 51) || o_lap_data !== pack(0, 0, 0, 50)) begin
         errors++;
         $display("FAIL lap_prestep: time=%h lap=%h expected %h %h",
                  time_now, o_lap_data, pack(0, 0, 0, 51), pack(0, 0, 0, 50));
      end
   endtask
`else
   task automatic test_lap_disabled();
      do_load(pack(1, 1, 1, 1));
      do_lap();
      do_lap();
      i_lap_rd = 1'b1;
      tick(1);
      i_lap_rd = 1'b0;
      checks++;
      if (o_lap_valid !== 1'b0 || o_lap_count !== 3'd0 || o_lap_ovf !== 1'b0 || o_lap_data !== 24'd0) begin
         errors++;
         $display("FAIL lap_tieoff: valid=%b cnt=%0d ovf=%b data=%h expected 0 0 0 000000",
                  o_lap_valid, o_lap_count, o_lap_ovf, o_lap_data);
      end
   endtask
`endif

   task automatic test_clear_priority();
      do_clear();
      do_load(pack(0, 0, 0, 10));
      do_lap();
      i_mode = 1'b0;
      i_run_stop = 1'b1;
      tick(9);
      i_clear = 1'b1;
      i_load = 1'b1;
      i_lap = 1'b1;
      i_preset = pack(3, 3, 3, 3);
      tick(1);
      i_clear = 1'b0;
      i_load = 1'b0;
      i_lap = 1'b0;
      checks++;
      if (time_now !== 24'd0 || o_lap_valid !== 1'b0 || o_lap_count !== 3'd0 || o_lap_ovf !== 1'b0) begin
         errors++;
         $display("FAIL clear_prio: time=%h valid=%b cnt=%0d ovf=%b expected 000000 0 0 0",
                  time_now, o_lap_valid, o_lap_count, o_lap_ovf);
      end
      tick(9);
      checks++;
      if (o_msec !== 7'd0) begin
         errors++;
         $display("FAIL clear_div9: msec=%0d expected 0", o_msec);
      end
      tick(1);
      checks++;
      if (o_msec !== 7'd1) begin
         errors++;
         $display("FAIL clear_div10: msec=%0d expected 1", o_msec);
      end
   endtask

   task automatic test_async_reset();
      i_run_stop = 1'b1;
      tick(25);
      do_lap();
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if (time_now !== 24'd0 || o_lap_valid !== 1'b0 || o_lap_count !== 3'd0 || o_lap_data !== 24'd0 ||
          o_lap_ovf !== 1'b0 || o_rollover !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: time=%h valid=%b cnt=%0d data=%h ovf=%b ro=%b done=%b expected all 0",
                  time_now, o_lap_valid, o_lap_count, o_lap_data, o_lap_ovf, o_rollover, o_done);
      end
      #2;
      reset = 1'b1;
      tick(9);
      checks++;
      if (o_msec !== 7'd0) begin
         errors++;
         $display("FAIL reset_restart9: msec=%0d expected 0", o_msec);
      end
      tick(1);
      checks++;
      if (o_msec !== 7'd1) begin
         errors++;
         $display("FAIL reset_restart10: msec=%0d expected 1", o_msec);
      end
      i_run_stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_run_hold();
      test_load_sat();
      test_carry();
      test_rollover();
      test_countdown();
      test_borrow_mode();
`ifdef STOPWATCH_LAP_BUFFER_EN
      test_lap_overflow();
      test_lap_full_rw();
      test_lap_prestep();
`else
      test_lap_disabled();
`endif
      test_clear_priority();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
